// File: rtl/fft_addr_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_addr_gen_if : control and RAM/ROM address bundle of the FFT sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface fft_addr_gen_if #(
  parameter int L_MAX = 9
);
  logic             start;
  logic [3:0]       log_n;
  logic             inverse;
  logic             hold;
  logic             rd_en;
  logic [L_MAX-1:0] rd_add1;
  logic [L_MAX-1:0] rd_add2;
  logic [L_MAX-2:0] tw_addr;
  logic             tw_conj;
  logic             wr_en;
  logic [L_MAX-1:0] wr_add1;
  logic [L_MAX-1:0] wr_add2;
  logic [3:0]       stage;
  logic             busy;
  logic             done;

  // Host side: issues requests and consumes the address streams.
  modport master (
    output start, log_n, inverse, hold,
    input  rd_en, rd_add1, rd_add2, tw_addr, tw_conj,
    input  wr_en, wr_add1, wr_add2, stage, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, log_n, inverse, hold,
    output rd_en, rd_add1, rd_add2, tw_addr, tw_conj,
    output wr_en, wr_add1, wr_add2, stage, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_addr_gen : in-place radix-2 DIT FFT read/write address and twiddle sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
module fft_addr_gen #(
  parameter int L_MAX   = 9,
  parameter int MIN_LOG = 3,
  parameter int LAT     = 3
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fft_addr_gen_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam int DW = 2 * L_MAX + 1;
  localparam logic [L_MAX:0]   c_ONE   = {{L_MAX{1'b0}}, 1'b1};
  localparam logic [L_MAX-1:0] c_J_ONE = {{(L_MAX-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [3:0]       r_s;
  logic [3:0]       r_log;
  logic [L_MAX-1:0] r_j;
  logic [L_MAX-1:0] r_k;
  logic [3:0]       r_dcnt;
  logic             r_conj;
  logic [L_MAX-1:0] r_add1;
  logic [L_MAX-1:0] r_add2;
  logic [L_MAX-2:0] r_tw;
  logic [DW-1:0]    r_dly [LAT];

  logic [L_MAX:0]   w_half;
  logic [L_MAX:0]   w_span;
  logic [L_MAX:0]   w_npts;
  logic [L_MAX:0]   w_k_next;
  logic             w_col_end;
  logic             w_stage_end;
  logic             w_issue;
  logic [L_MAX-1:0] w_add1;
  logic [L_MAX-1:0] w_add2;
  logic [L_MAX-2:0] w_tw;
  logic [3:0]       w_log_clamp;

  // Loop geometry of the current stage; one extra bit keeps k+2^s from wrapping.
  assign w_half      = c_ONE << (r_s - 4'd1);
  assign w_span      = c_ONE << r_s;
  assign w_npts      = c_ONE << r_log;
  assign w_k_next    = {1'b0, r_k} + w_span;
  assign w_col_end   = (w_k_next >= w_npts);
  assign w_stage_end = w_col_end && ({1'b0, r_j} == (w_half - c_ONE));
  assign w_issue     = (r_state == c_RUN) && !bus.hold;

  assign w_add1 = r_k;
  assign w_add2 = r_k + w_half[L_MAX-1:0];
  assign w_tw   = r_j[L_MAX-2:0] << (4'(L_MAX) - r_s);

  always_comb begin
    w_log_clamp = bus.log_n;
    if (bus.log_n < 4'(MIN_LOG)) begin
      w_log_clamp = 4'(MIN_LOG);
    end else if (bus.log_n > 4'(L_MAX)) begin
      w_log_clamp = 4'(L_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_s     <= 4'd0;
      r_log   <= 4'd0;
      r_j     <= '0;
      r_k     <= '0;
      r_dcnt  <= 4'd0;
      r_conj  <= 1'b0;
      r_add1  <= '0;
      r_add2  <= '0;
      r_tw    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_log   <= w_log_clamp;
            r_conj  <= bus.inverse;
            r_s     <= 4'd1;
            r_j     <= '0;
            r_k     <= '0;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          if (w_issue) begin
            r_add1 <= w_add1;
            r_add2 <= w_add2;
            r_tw   <= w_tw;
            if (w_stage_end) begin
              r_dcnt  <= 4'(LAT - 1);
              r_state <= c_DRAIN;
            end else if (w_col_end) begin
              r_j <= r_j + c_J_ONE;
              r_k <= r_j + c_J_ONE;
            end else begin
              r_k <= w_k_next[L_MAX-1:0];
            end
          end
        end
        c_DRAIN: begin
          // Let every write of this stage land before the next stage reads.
          if (r_dcnt == 4'd0) begin
            if (r_s < r_log) begin
              r_s     <= r_s + 4'd1;
              r_j     <= '0;
              r_k     <= '0;
              r_state <= c_RUN;
            end else begin
              r_state <= c_DONE;
            end
          end else begin
            r_dcnt <= r_dcnt - 4'd1;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Read side; addresses hold their last issued value while not issuing.
  assign bus.rd_en   = w_issue;
  assign bus.rd_add1 = w_issue ? w_add1 : r_add1;
  assign bus.rd_add2 = w_issue ? w_add2 : r_add2;
  assign bus.tw_addr = w_issue ? w_tw   : r_tw;
  assign bus.tw_conj = r_conj;
  assign bus.stage   = (r_state == c_IDLE) ? 4'd0 : r_s;
  assign bus.busy    = (r_state != c_IDLE);
  assign bus.done    = (r_state == c_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_dly[i] <= '0;
      end
    end else begin
      r_dly[0] <= {bus.rd_en, bus.rd_add1, bus.rd_add2};
      for (int i = 1; i < LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign bus.wr_en   = r_dly[LAT-1][DW-1];
  assign bus.wr_add1 = r_dly[LAT-1][2*L_MAX-1:L_MAX];
  assign bus.wr_add2 = r_dly[LAT-1][L_MAX-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fft_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fft_addr_gen : directed table-driven bench for fft_addr_gen
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fft_addr_gen;

  localparam int L_MAX = 9;
  localparam int LAT   = 3;

  typedef struct {
    logic [3:0] ln;
    logic       inv;
    int         hold_at;
    int         hold_len;
    int         busy_at;
    int         eff;
    int         done_cyc;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [8:0] a1;
    logic [8:0] a2;
    logic [7:0] tw;
    logic [3:0] stg;
    logic       conj;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   t0 = 0;
  int   done_cnt = 0;
  int   done_rel = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   rd_b, wr_b, done_b;
  logic hs_en;
  logic [8:0] hs_a1, hs_a2;
  rec_t rd_q[$];
  rec_t wr_q[$];
  int   hits [10][512];
  vec_t vecs [8];
  int   exp_a1 [12] = '{0, 2, 4, 6, 0, 4, 1, 5, 0, 1, 2, 3};
  int   exp_a2 [12] = '{1, 3, 5, 7, 2, 6, 3, 7, 4, 5, 6, 7};
  int   exp_tw [12] = '{0, 0, 0, 0, 0, 0, 128, 128, 0, 64, 128, 192};

  fft_addr_gen_if #(.L_MAX(L_MAX)) bus ();

  fft_addr_gen #(.L_MAX(L_MAX), .MIN_LOG(3), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rd_en) rd_q.push_back('{cyc - t0, bus.rd_add1, bus.rd_add2, bus.tw_addr, bus.stage, bus.tw_conj});
    if (bus.wr_en) wr_q.push_back('{cyc - t0, bus.wr_add1, bus.wr_add2, 8'd0, 4'd0, 1'b0});
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_rel <= cyc - t0;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_fft(input vec_t v);
    int rel;
    @(posedge clk); #1;
    rd_b = rd_q.size();
    wr_b = wr_q.size();
    done_b = done_cnt;
    t0 = cyc;
    bus.log_n = v.ln;
    bus.inverse = v.inv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 0; n < 6000 && done_cnt == done_b; n++) begin
      rel = cyc - t0;
      bus.hold = (v.hold_len > 0) && (rel >= v.hold_at) && (rel < v.hold_at + v.hold_len);
      if (v.hold_len > 0 && rel == v.hold_at + 2) begin
        hs_en = bus.rd_en;
        hs_a1 = bus.rd_add1;
        hs_a2 = bus.rd_add2;
      end
      bus.start = (v.busy_at > 0) && (rel == v.busy_at);
      if (bus.start) begin
        bus.log_n = 4'd9;
        bus.inverse = ~v.inv;
      end
      @(posedge clk); #1;
    end
    bus.hold = 1'b0;
    bus.start = 1'b0;
    chk("done_pulses", done_cnt - done_b, 1);
    chk("idle_after_done", {28'd0, bus.busy, bus.stage}, 0);
  endtask

  task automatic check_run(input vec_t v);
    int err, idx, nrd, half;
    nrd = v.eff * (1 << (v.eff - 1));
    half = 1 << (v.eff - 1);
    chk("done_cycle", done_rel, v.done_cyc);
    chk("rd_count", rd_q.size() - rd_b, nrd);
    err = 0;
    idx = rd_b;
    for (int s = 1; s <= v.eff; s++)
      for (int j = 0; j < (1 << (s - 1)); j++)
        for (int k = j; k < (1 << v.eff); k += (1 << s)) begin
          if (idx >= rd_q.size()) err++;
          else if (rd_q[idx].a1 != 9'(k) || rd_q[idx].a2 != 9'(k + (1 << (s - 1))) ||
                   rd_q[idx].tw != 8'(j << (L_MAX - s)) || rd_q[idx].stg != 4'(s)) err++;
          idx++;
        end
    chk("rd_seq_errors", err, 0);
    err = 0;
    for (int i = rd_b; i < rd_q.size(); i++)
      if (rd_q[i].conj != v.inv) err++;
    chk("tw_conj_errors", err, 0);
    chk("wr_count", wr_q.size() - wr_b, rd_q.size() - rd_b);
    err = 0;
    for (int i = 0; i < wr_q.size() - wr_b && i < rd_q.size() - rd_b; i++)
      if (wr_q[wr_b+i].cyc != rd_q[rd_b+i].cyc + LAT || wr_q[wr_b+i].a1 != rd_q[rd_b+i].a1 ||
          wr_q[wr_b+i].a2 != rd_q[rd_b+i].a2) err++;
    chk("wr_delay_errors", err, 0);
    foreach (hits[s, a]) hits[s][a] = 0;
    for (int i = 0; i < wr_q.size() - wr_b && i < nrd; i++) begin
      hits[i / half + 1][wr_q[wr_b+i].a1]++;
      hits[i / half + 1][wr_q[wr_b+i].a2]++;
    end
    err = 0;
    for (int s = 1; s <= v.eff; s++)
      for (int a = 0; a < (1 << v.eff); a++)
        if (hits[s][a] != 1) err++;
    chk("wr_cover_errors", err, 0);
  endtask

  initial begin
    vec_t rv;
    int err;
    vecs[0] = '{4'd3,  1'b0, 0,  0, 0, 3, 22};
    vecs[1] = '{4'd4,  1'b1, 0,  0, 0, 4, 45};
    vecs[2] = '{4'd2,  1'b0, 0,  0, 0, 3, 22};
    vecs[3] = '{4'd12, 1'b1, 0,  0, 0, 9, 2332};
    vecs[4] = '{4'd9,  1'b0, 0,  0, 0, 9, 2332};
    vecs[5] = '{4'd4,  1'b0, 14, 5, 0, 4, 50};
    vecs[6] = '{4'd3,  1'b1, 0,  0, 5, 3, 22};
    vecs[7] = '{4'd5,  1'b0, 0,  0, 0, 5, 96};
    bus.start = 1'b0;
    bus.log_n = 4'd0;
    bus.inverse = 1'b0;
    bus.hold = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.tw_conj, bus.stage,
                          bus.rd_add1, bus.rd_add2, bus.tw_addr, bus.wr_add1, bus.wr_add2}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {bus.busy, bus.done, bus.rd_en, bus.stage}, 0);

    for (int i = 0; i < 8; i++) begin
      run_fft(vecs[i]);
      check_run(vecs[i]);
      if (i == 0) begin
        err = 0;
        for (int n = 0; n < 12; n++)
          if (rd_q[rd_b+n].a1 != 9'(exp_a1[n]) || rd_q[rd_b+n].a2 != 9'(exp_a2[n]) ||
              rd_q[rd_b+n].tw != 8'(exp_tw[n])) err++;
        chk("basic_table_errors", err, 0);
        chk("first_read_cycle", rd_q[rd_b].cyc, 1);
      end
      if (vecs[i].hold_len > 0) begin
        chk("hold_rd_en", hs_en, 0);
        chk("hold_rd_add1", hs_a1, 4);
        chk("hold_rd_add2", hs_a2, 6);
      end
    end

    // Reset mid stage 2: outputs clear at once and no done follows.
    @(posedge clk); #1;
    t0 = cyc;
    done_b = done_cnt;
    bus.log_n = 4'd4;
    bus.inverse = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("busy_before_rst", {bus.busy, bus.stage}, 5'h12);
    rst = 1'b1;
    #1;
    chk("rst_midrun_outputs", {bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.tw_conj, bus.stage,
                               bus.rd_add1, bus.rd_add2, bus.tw_addr, bus.wr_add1, bus.wr_add2}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt - done_b, 0);
    chk("idle_after_rst", bus.busy, 0);
    rv = '{4'd3, 1'b0, 0, 0, 0, 3, 22};
    run_fft(rv);
    check_run(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
